// File: rtl/alu_seq.sv
// alu_seq: small register-file sequencer that issues one command at a time
// to an external combinational ALU and writes the result back (or loads the
// compare flags) before reporting completion through a valid/ready handshake.
`timescale 1ns/1ps
module alu_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [2:0]        cmd_rd,
    input  logic [2:0]        cmd_rs,
    input  logic [2:0]        cmd_rt,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [2:0]        alu_aluop,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_equal,
    input  logic              alu_less,
    output logic              done_valid,
    input  logic              done_ready,
    output logic              flag_eq,
    output logic              flag_lt,
    input  logic              ld_en,
    input  logic [2:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // Highest opcode that produces a register result; above it are compares.
    localparam logic [2:0] OP_LAST_ARITH = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2:0]        rd_q, rd_d;
    logic [2:0]        rs_q, rs_d;
    logic [2:0]        rt_q, rt_d;
    logic [DATA_W-1:0] rf_q [8];
    logic [DATA_W-1:0] rf_d [8];
    logic              flag_eq_q, flag_eq_d;
    logic              flag_lt_q, flag_lt_d;

    // Next-state: command latch, direct loads, then ALU write-back (applied last so it wins a collision).
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rf_d      = rf_q;
        flag_eq_d = flag_eq_q;
        flag_lt_d = flag_lt_q;

        if (ld_en) begin
            rf_d[ld_addr] = ld_data;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rd_d    = cmd_rd;
                    rs_d    = cmd_rs;
                    rt_d    = cmd_rt;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (op_q <= OP_LAST_ARITH) begin
                    rf_d[rd_q] = alu_result;
                end else begin
                    flag_eq_d = alu_equal;
                    flag_lt_d = alu_less;
                end
                state_d = WB;
            end
            WB: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any in-flight command and clears the register file and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= 3'd0;
            rd_q      <= 3'd0;
            rs_q      <= 3'd0;
            rt_q      <= 3'd0;
            flag_eq_q <= 1'b0;
            flag_lt_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            flag_eq_q <= flag_eq_d;
            flag_lt_q <= flag_lt_d;
            rf_q      <= rf_d;
        end
    end

    // Handshakes and ALU drive decode straight from the state register; ALU inputs are zero outside ISSUE.
    always_comb begin
        cmd_ready  = (state_q == IDLE);
        done_valid = (state_q == WB);
        alu_op1    = '0;
        alu_op2    = '0;
        alu_aluop  = 3'd0;
        if (state_q == ISSUE) begin
            alu_op1   = rf_q[rs_q];
            alu_op2   = rf_q[rt_q];
            alu_aluop = op_q;
        end
    end

    // Flag outputs and the debug read port expose the stored state directly.
    always_comb begin
        flag_eq  = flag_eq_q;
        flag_lt  = flag_lt_q;
        dbg_data = rf_q[dbg_addr];
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks with hand-computed values plus a randomized run
// compared every cycle against a transaction-level model of the sequencer.
`timescale 1ns/1ps
module tb_alu_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op, cmd_rd, cmd_rs, cmd_rt;
    logic [7:0] alu_op1, alu_op2;
    logic [2:0] alu_aluop;
    logic [7:0] alu_result;
    logic       alu_equal, alu_less;
    logic       done_valid, done_ready;
    logic       flag_eq, flag_lt;
    logic       ld_en;
    logic [2:0] ld_addr;
    logic [7:0] ld_data;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_vectors;
    int n_miscompares;
    bit check_en;

    alu_seq #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_aluop  (alu_aluop),
        .alu_result (alu_result),
        .alu_equal  (alu_equal),
        .alu_less   (alu_less),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .flag_eq    (flag_eq),
        .flag_lt    (flag_lt),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // External ALU: returns {less, equal, result}; equal only meaningful for SLTE/EQ, less for SLT/SLTE.
    function automatic logic [9:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       eq;
        logic       lt;
        r  = 8'h00;
        eq = 1'b0;
        lt = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = a + b;
            3'd4: r = a - b;
            3'd5: begin lt = (a < b);  r = {7'b0, lt}; end
            3'd6: begin lt = (a <= b); eq = (a == b); r = {7'b0, lt}; end
            default: begin eq = (a == b); r = {7'b0, eq}; end
        endcase
        return {lt, eq, r};
    endfunction

    assign {alu_less, alu_equal, alu_result} = alu_fn(alu_aluop, alu_op1, alu_op2);

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: register contents, flags, and the in-flight command with its age in cycles.
    logic [7:0] mrf [8];
    logic       mflag_eq, mflag_lt;
    bit         busy;
    int         age;
    logic [2:0] m_op, m_rd, m_rs, m_rt;
    logic [9:0] m_res;

    assign m_res = alu_fn(m_op, mrf[m_rs], mrf[m_rt]);

    // Model update: loads land first, an arithmetic write-back on the same edge overrides them.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mrf[i] <= 8'h00;
            mflag_eq <= 1'b0;
            mflag_lt <= 1'b0;
            busy     <= 1'b0;
            age      <= 0;
        end else begin
            if (ld_en) mrf[ld_addr] <= ld_data;
            if (busy) begin
                if (age == 1) begin
                    if (m_op <= 3'd4) mrf[m_rd] <= m_res[7:0];
                    else begin
                        mflag_eq <= m_res[8];
                        mflag_lt <= m_res[9];
                    end
                    age <= 2;
                end else if (done_ready) begin
                    busy <= 1'b0;
                end
            end else if (cmd_valid) begin
                busy <= 1'b1;
                age  <= 1;
                m_op <= cmd_op;
                m_rd <= cmd_rd;
                m_rs <= cmd_rs;
                m_rt <= cmd_rt;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic exp);
        checkOutput(name, {7'b0, got}, {7'b0, exp});
    endtask

    // Per-cycle comparison of every observable output against the model, away from the rising edge.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            checkBit("cmd_ready", cmd_ready, !busy);
            checkBit("done_valid", done_valid, busy && (age == 2));
            checkOutput("alu_op1", alu_op1, (busy && age == 1) ? mrf[m_rs] : 8'h00);
            checkOutput("alu_op2", alu_op2, (busy && age == 1) ? mrf[m_rt] : 8'h00);
            checkOutput("alu_aluop", {5'b0, alu_aluop}, {5'b0, (busy && age == 1) ? m_op : 3'd0});
            checkBit("flag_eq", flag_eq, mflag_eq);
            checkBit("flag_lt", flag_lt, mflag_lt);
            checkOutput("dbg_data", dbg_data, mrf[dbg_addr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic loadReg(input logic [2:0] a, input logic [7:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic checkReg(input string name, input logic [2:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        checkOutput(name, dbg_data, exp);
    endtask

    // Offer one command while idle; returns in the ISSUE cycle.
    task automatic sendCmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_rt    = rt;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finishCmd();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    task automatic applyStimulus();
        cmd_valid  = ($urandom_range(0, 1) == 1);
        cmd_op     = 3'($urandom_range(0, 7));
        cmd_rd     = 3'($urandom_range(0, 7));
        cmd_rs     = 3'($urandom_range(0, 7));
        cmd_rt     = 3'($urandom_range(0, 7));
        done_ready = ($urandom_range(0, 2) != 0);
        ld_en      = ($urandom_range(0, 3) == 0);
        ld_addr    = 3'($urandom_range(0, 7));
        ld_data    = 8'($urandom_range(0, 255));
        dbg_addr   = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset checks, directed scenarios, then randomized traffic.
    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        check_en      = 1'b0;
        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_op        = 3'd0;
        cmd_rd        = 3'd0;
        cmd_rs        = 3'd0;
        cmd_rt        = 3'd0;
        done_ready    = 1'b0;
        ld_en         = 1'b0;
        ld_addr       = 3'd0;
        ld_data       = 8'h00;
        dbg_addr      = 3'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] reset state");
        checkBit("rst_cmd_ready", cmd_ready, 1'b1);
        checkBit("rst_done_valid", done_valid, 1'b0);
        checkBit("rst_flag_eq", flag_eq, 1'b0);
        checkBit("rst_flag_lt", flag_lt, 1'b0);
        checkOutput("rst_alu_op1", alu_op1, 8'h00);
        checkOutput("rst_alu_aluop", {5'b0, alu_aluop}, 8'h00);
        for (int i = 0; i < 8; i++) checkReg("rst_rf", 3'(i), 8'h00);
        tick();
        check_en = 1'b1;

        $display("[TB] ADD with wrap");
        resetDut();
        loadReg(3'd1, 8'h0F);
        loadReg(3'd2, 8'hF1);
        sendCmd(3'd3, 3'd3, 3'd1, 3'd2);
        checkOutput("add_alu_op1", alu_op1, 8'h0F);
        checkOutput("add_alu_op2", alu_op2, 8'hF1);
        checkOutput("add_alu_aluop", {5'b0, alu_aluop}, 8'h03);
        checkBit("add_issue_cmd_ready", cmd_ready, 1'b0);
        tick();
        checkBit("add_done_valid", done_valid, 1'b1);
        checkReg("add_wrap_rf3", 3'd3, 8'h00);
        checkBit("add_flag_eq", flag_eq, 1'b0);
        checkBit("add_flag_lt", flag_lt, 1'b0);
        finishCmd();

        $display("[TB] SLTE then SLT on equal operands");
        resetDut();
        loadReg(3'd1, 8'h05);
        loadReg(3'd2, 8'h05);
        loadReg(3'd7, 8'hA5);
        sendCmd(3'd6, 3'd7, 3'd1, 3'd2);
        tick();
        checkBit("slte_flag_eq", flag_eq, 1'b1);
        checkBit("slte_flag_lt", flag_lt, 1'b1);
        checkReg("slte_rf7_kept", 3'd7, 8'hA5);
        finishCmd();
        sendCmd(3'd5, 3'd7, 3'd1, 3'd2);
        tick();
        checkBit("slt_flag_eq", flag_eq, 1'b0);
        checkBit("slt_flag_lt", flag_lt, 1'b0);
        checkReg("slt_rf7_kept", 3'd7, 8'hA5);
        finishCmd();

        $display("[TB] completion backpressure");
        sendCmd(3'd3, 3'd0, 3'd1, 3'd2);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkBit("hold_done_valid", done_valid, 1'b1);
            checkBit("hold_cmd_ready", cmd_ready, 1'b0);
            tick();
        end
        finishCmd();
        checkBit("release_cmd_ready", cmd_ready, 1'b1);
        checkBit("release_done_valid", done_valid, 1'b0);

        $display("[TB] back-to-back commands");
        cmd_valid  = 1'b1;
        done_ready = 1'b1;
        cmd_op     = 3'd1;
        cmd_rd     = 3'd0;
        cmd_rs     = 3'd1;
        cmd_rt     = 3'd2;
        tick();
        checkBit("b2b_first_busy", cmd_ready, 1'b0);
        checkOutput("b2b_first_aluop", {5'b0, alu_aluop}, 8'h01);
        cmd_op = 3'd2;
        tick();
        checkBit("b2b_wb_done", done_valid, 1'b1);
        tick();
        checkBit("b2b_idle_ready", cmd_ready, 1'b1);
        tick();
        checkBit("b2b_second_busy", cmd_ready, 1'b0);
        checkOutput("b2b_second_aluop", {5'b0, alu_aluop}, 8'h02);
        cmd_valid = 1'b0;
        tick();
        tick();
        done_ready = 1'b0;
        checkBit("b2b_end_ready", cmd_ready, 1'b1);

        $display("[TB] load collision with write-back");
        resetDut();
        loadReg(3'd1, 8'h30);
        loadReg(3'd2, 8'h0E);
        sendCmd(3'd4, 3'd4, 3'd1, 3'd2);
        ld_en   = 1'b1;
        ld_addr = 3'd4;
        ld_data = 8'h99;
        tick();
        ld_en = 1'b0;
        checkReg("collide_rf4", 3'd4, 8'h22);
        finishCmd();
        sendCmd(3'd4, 3'd4, 3'd1, 3'd2);
        ld_en   = 1'b1;
        ld_addr = 3'd5;
        ld_data = 8'h99;
        tick();
        ld_en = 1'b0;
        checkReg("side_rf4", 3'd4, 8'h22);
        checkReg("side_rf5", 3'd5, 8'h99);
        finishCmd();

        $display("[TB] reset during ISSUE");
        resetDut();
        loadReg(3'd1, 8'h05);
        loadReg(3'd2, 8'h05);
        sendCmd(3'd6, 3'd0, 3'd1, 3'd2);
        tick();
        finishCmd();
        checkBit("pre_abort_flag_eq", flag_eq, 1'b1);
        loadReg(3'd6, 8'h55);
        loadReg(3'd1, 8'h0F);
        loadReg(3'd2, 8'hF0);
        sendCmd(3'd2, 3'd6, 3'd1, 3'd2);
        rst_n = 1'b0;
        #1;
        checkBit("abort_flag_eq", flag_eq, 1'b0);
        checkBit("abort_flag_lt", flag_lt, 1'b0);
        checkBit("abort_done_valid", done_valid, 1'b0);
        checkOutput("abort_alu_op1", alu_op1, 8'h00);
        checkReg("abort_rf6", 3'd6, 8'h00);
        rst_n = 1'b1;
        tick();
        checkBit("abort_cmd_ready", cmd_ready, 1'b1);
        checkBit("abort_no_done_1", done_valid, 1'b0);
        tick();
        checkBit("abort_no_done_2", done_valid, 1'b0);
        checkReg("abort_rf6_after", 3'd6, 8'h00);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus();
            tick();
        end
        cmd_valid  = 1'b0;
        ld_en      = 1'b0;
        done_ready = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
